// File: rtl/filter_arbiter.sv
// Two-requester round-robin front end for one shared filter; a tag FIFO
// remembers which requester owns each sample in flight so results route back.
module filter_arbiter #(
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] src0_aud,
  input  logic [31:0] src1_aud,
  input  logic        src0_rts,
  input  logic        src1_rts,
  output logic        src0_rtr,
  output logic        src1_rtr,
  output logic [31:0] flt_aud_in,
  output logic        flt_aud_in_rts,
  input  logic        flt_aud_in_rtr,
  input  logic [31:0] flt_aud_out,
  input  logic        flt_aud_out_rts,
  output logic        flt_aud_out_rtr,
  output logic [31:0] dst0_aud,
  output logic [31:0] dst1_aud,
  output logic        dst0_rts,
  output logic        dst1_rts,
  input  logic        dst0_rtr,
  input  logic        dst1_rtr,
  input  logic [1:0]  rf_arb_en,
  input  logic        trig_arb_orphan_clear,
  output logic        ro_arb_orphan_flag,
  output logic [15:0] ro_src0_count,
  output logic [15:0] ro_src1_count
);

  localparam int unsigned AW = (TAG_DEPTH > 2) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(TAG_DEPTH);

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          occ;
  logic                 prio;

  logic elig0, elig1, any_elig, winner;
  logic full, empty, head;
  logic push, pop, orphan;

  assign elig0    = src0_rts & rf_arb_en[0];
  assign elig1    = src1_rts & rf_arb_en[1];
  assign any_elig = elig0 | elig1;
  assign full     = (occ == FULL_LVL);
  assign empty    = (occ == '0);
  assign head     = tag_mem[rd_ptr];

  always_comb begin
    winner = 1'b0;
    if (elig0 && elig1) winner = prio;
    else if (elig1)     winner = 1'b1;
  end

  assign flt_aud_in_rts = any_elig & ~full;
  assign flt_aud_in     = !any_elig ? '0 : (winner ? src1_aud : src0_aud);
  assign src0_rtr       = any_elig & ~winner & flt_aud_in_rtr & ~full;
  assign src1_rtr       = any_elig &  winner & flt_aud_in_rtr & ~full;
  assign push           = flt_aud_in_rts & flt_aud_in_rtr;

  // Empty FIFO: the filter's sample has no owner, so accept and drop it.
  always_comb begin
    dst0_rts        = 1'b0;
    dst1_rts        = 1'b0;
    dst0_aud        = '0;
    dst1_aud        = '0;
    flt_aud_out_rtr = 1'b1;
    if (!empty) begin
      if (head) begin
        dst1_rts        = flt_aud_out_rts;
        dst1_aud        = flt_aud_out_rts ? flt_aud_out : '0;
        flt_aud_out_rtr = dst1_rtr;
      end else begin
        dst0_rts        = flt_aud_out_rts;
        dst0_aud        = flt_aud_out_rts ? flt_aud_out : '0;
        flt_aud_out_rtr = dst0_rtr;
      end
    end
  end

  assign pop    = ~empty & flt_aud_out_rts & flt_aud_out_rtr;
  assign orphan =  empty & flt_aud_out_rts;

  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      occ                <= '0;
      prio               <= 1'b0;
      ro_src0_count      <= '0;
      ro_src1_count      <= '0;
      ro_arb_orphan_flag <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= winner;
        wr_ptr          <= wr_ptr + AW'(1);
        prio            <= ~winner;
        if (winner) ro_src1_count <= ro_src1_count + 16'd1;
        else        ro_src0_count <= ro_src0_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (orphan)                     ro_arb_orphan_flag <= 1'b1;
      else if (trig_arb_orphan_clear) ro_arb_orphan_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filter_arbiter.sv
// Scoreboard bench for filter_arbiter: an emulated filter returns accepted
// samples in order (XOR key) and every routed result is checked against the queue.
module tb_filter_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        tag;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] src0_aud, src1_aud;
  logic        src0_rts, src1_rts, src0_rtr, src1_rtr;
  logic [31:0] flt_aud_in;
  logic        flt_aud_in_rts, flt_aud_in_rtr;
  logic [31:0] flt_aud_out;
  logic        flt_aud_out_rts, flt_aud_out_rtr;
  logic [31:0] dst0_aud, dst1_aud;
  logic        dst0_rts, dst1_rts, dst0_rtr, dst1_rtr;
  logic [1:0]  rf_arb_en;
  logic        trig_arb_orphan_clear;
  logic        ro_arb_orphan_flag;
  logic [15:0] ro_src0_count, ro_src1_count;

  filter_arbiter #(.TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .rstb(rstb),
    .src0_aud(src0_aud), .src1_aud(src1_aud),
    .src0_rts(src0_rts), .src1_rts(src1_rts),
    .src0_rtr(src0_rtr), .src1_rtr(src1_rtr),
    .flt_aud_in(flt_aud_in), .flt_aud_in_rts(flt_aud_in_rts), .flt_aud_in_rtr(flt_aud_in_rtr),
    .flt_aud_out(flt_aud_out), .flt_aud_out_rts(flt_aud_out_rts), .flt_aud_out_rtr(flt_aud_out_rtr),
    .dst0_aud(dst0_aud), .dst1_aud(dst1_aud),
    .dst0_rts(dst0_rts), .dst1_rts(dst1_rts),
    .dst0_rtr(dst0_rtr), .dst1_rtr(dst1_rtr),
    .rf_arb_en(rf_arb_en), .trig_arb_orphan_clear(trig_arb_orphan_clear),
    .ro_arb_orphan_flag(ro_arb_orphan_flag),
    .ro_src0_count(ro_src0_count), .ro_src1_count(ro_src1_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ent_t        sb[$];
  logic        mprio;
  logic [15:0] mcnt0, mcnt1;
  logic        mflag;
  logic [31:0] fkey;
  logic        filt_en, orph_inj;
  logic [31:0] got0, got1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic chk_idle();
    check("idle_src0_rtr", {31'd0, src0_rtr}, 32'd0);
    check("idle_src1_rtr", {31'd0, src1_rtr}, 32'd0);
    check("idle_in_rts", {31'd0, flt_aud_in_rts}, 32'd0);
    check("idle_in_aud", flt_aud_in, 32'd0);
    check("idle_out_rtr", {31'd0, flt_aud_out_rtr}, 32'd1);
    check("idle_dst0_rts", {31'd0, dst0_rts}, 32'd0);
    check("idle_dst1_rts", {31'd0, dst1_rts}, 32'd0);
    check("idle_dst0_aud", dst0_aud, 32'd0);
    check("idle_dst1_aud", dst1_aud, 32'd0);
    check("idle_cnt0", {16'd0, ro_src0_count}, 32'd0);
    check("idle_cnt1", {16'd0, ro_src1_count}, 32'd0);
    check("idle_flag", {31'd0, ro_arb_orphan_flag}, 32'd0);
  endtask

  // One clock: drive the emulated filter, check comb outputs, commit the model.
  task automatic tick();
    logic e0, e1, win, full, any, in_acc, had, out_acc, orphan_now, drv_rts;
    logic d0r, d1r, exp_out_rtr;
    logic [31:0] drv_aud;
    ent_t head, ne;
    had  = (sb.size() != 0);
    head = had ? sb[0] : '0;
    if (orph_inj) begin
      drv_rts = 1'b1; drv_aud = 32'hDEAD0000;
    end else if (filt_en && had) begin
      drv_rts = 1'b1; drv_aud = head.data ^ fkey;
    end else begin
      drv_rts = 1'b0; drv_aud = '0;
    end
    flt_aud_out_rts = drv_rts;
    flt_aud_out     = drv_aud;
    #1;
    e0   = src0_rts & rf_arb_en[0];
    e1   = src1_rts & rf_arb_en[1];
    any  = e0 | e1;
    win  = (e0 & e1) ? mprio : e1;
    full = (sb.size() == DEPTH);
    in_acc = any & ~full & flt_aud_in_rtr;
    check("in_rts", {31'd0, flt_aud_in_rts}, {31'd0, any & ~full});
    check("in_aud", flt_aud_in, !any ? 32'd0 : (win ? src1_aud : src0_aud));
    check("src0_rtr", {31'd0, src0_rtr}, {31'd0, in_acc & ~win});
    check("src1_rtr", {31'd0, src1_rtr}, {31'd0, in_acc & win});
    d0r = had & ~head.tag & drv_rts;
    d1r = had &  head.tag & drv_rts;
    exp_out_rtr = had ? (head.tag ? dst1_rtr : dst0_rtr) : 1'b1;
    check("dst0_rts", {31'd0, dst0_rts}, {31'd0, d0r});
    check("dst1_rts", {31'd0, dst1_rts}, {31'd0, d1r});
    check("dst0_aud", dst0_aud, d0r ? drv_aud : 32'd0);
    check("dst1_aud", dst1_aud, d1r ? drv_aud : 32'd0);
    check("out_rtr", {31'd0, flt_aud_out_rtr}, {31'd0, exp_out_rtr});
    out_acc    = drv_rts & exp_out_rtr;
    orphan_now = ~had & drv_rts;
    if (dst0_rts && dst0_rtr) got0 = dst0_aud;
    if (dst1_rts && dst1_rtr) got1 = dst1_aud;
    ne.tag  = win;
    ne.data = win ? src1_aud : src0_aud;
    @(posedge clk);
    if (rstb) begin
      sb.delete();
      mprio = 1'b0; mcnt0 = '0; mcnt1 = '0; mflag = 1'b0;
    end else begin
      if (out_acc && had) void'(sb.pop_front());
      if (in_acc) begin
        sb.push_back(ne);
        mprio = ~win;
        if (win) mcnt1 = mcnt1 + 16'd1;
        else     mcnt0 = mcnt0 + 16'd1;
      end
      if (orphan_now)                 mflag = 1'b1;
      else if (trig_arb_orphan_clear) mflag = 1'b0;
    end
    #1;
    check("flag", {31'd0, ro_arb_orphan_flag}, {31'd0, mflag});
    check("cnt0", {16'd0, ro_src0_count}, {16'd0, mcnt0});
    check("cnt1", {16'd0, ro_src1_count}, {16'd0, mcnt1});
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b1;
    src0_aud = '0; src1_aud = '0; src0_rts = 1'b0; src1_rts = 1'b0;
    flt_aud_in_rtr = 1'b1; flt_aud_out = '0; flt_aud_out_rts = 1'b0;
    dst0_rtr = 1'b1; dst1_rtr = 1'b1; rf_arb_en = 2'b11; trig_arb_orphan_clear = 1'b0;
    mprio = 1'b0; mcnt0 = '0; mcnt1 = '0; mflag = 1'b0;
    fkey = 32'h5A5A0F0F; filt_en = 1'b1; orph_inj = 1'b0; got0 = '0; got1 = '0;
    repeat (3) @(negedge clk);
    #1; chk_idle();
    rstb = 1'b0;
    #1; chk_idle();

    // Both requesters streaming: grants alternate, four each after eight.
    src0_rts = 1'b1; src1_rts = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src0_aud = 32'hA000_0000 + 32'(i);
      src1_aud = 32'hB000_0000 + 32'(i);
      tick();
    end
    src0_rts = 1'b0; src1_rts = 1'b0;
    check("alt_cnt0", {16'd0, ro_src0_count}, 32'd4);
    check("alt_cnt1", {16'd0, ro_src1_count}, 32'd4);
    repeat (3) tick();

    // Filter output stalled: the tag FIFO fills and input is blocked.
    filt_en = 1'b0; src0_rts = 1'b1; src1_rts = 1'b1;
    src0_aud = 32'hC0C0_0001; src1_aud = 32'hD0D0_0002;
    repeat (DEPTH) tick();
    check("stall_in_rts", {31'd0, flt_aud_in_rts}, 32'd0);
    check("stall_rtr0", {31'd0, src0_rtr}, 32'd0);
    check("stall_rtr1", {31'd0, src1_rtr}, 32'd0);
    filt_en = 1'b1; tick();
    filt_en = 1'b0;
    check("reopen_in_rts", {31'd0, flt_aud_in_rts}, 32'd1);
    tick();
    src0_rts = 1'b0; src1_rts = 1'b0; filt_en = 1'b1;
    repeat (DEPTH + 2) tick();

    // Echo filter: each result returns to the requester that sent it.
    fkey = '0; filt_en = 1'b0;
    src0_rts = 1'b1; src0_aud = 32'h1111_1111; tick();
    src0_rts = 1'b0; src1_rts = 1'b1; src1_aud = 32'h2222_2222; tick();
    src1_rts = 1'b0; filt_en = 1'b1;
    tick();
    check("echo_dst0", got0, 32'h1111_1111);
    tick();
    check("echo_dst1", got1, 32'h2222_2222);
    fkey = 32'h5A5A0F0F;

    // Enable changes with tags in flight, and a slow destination.
    filt_en = 1'b0; src0_rts = 1'b1; src1_rts = 1'b1;
    src0_aud = 32'h0000_00A0; src1_aud = 32'h0000_00B1;
    repeat (3) tick();
    rf_arb_en = 2'b00; filt_en = 1'b1; dst1_rtr = 1'b0;
    repeat (2) tick();
    dst1_rtr = 1'b1;
    repeat (4) tick();
    src0_rts = 1'b0; src1_rts = 1'b0; rf_arb_en = 2'b11;

    // Requester 1 disabled from reset: only requester 0 is served.
    reset_pulse();
    rf_arb_en = 2'b01; src0_rts = 1'b1; src1_rts = 1'b1;
    for (int i = 0; i < 6; i++) begin
      src0_aud = 32'h5000_0000 + 32'(i);
      src1_aud = 32'h6000_0000 + 32'(i);
      tick();
    end
    check("dis_cnt1", {16'd0, ro_src1_count}, 32'd0);
    check("dis_cnt0", {16'd0, ro_src0_count}, 32'd6);
    src0_rts = 1'b0; src1_rts = 1'b0; rf_arb_en = 2'b11;
    repeat (3) tick();

    // Orphan flag: set, clear, and set winning over a coincident clear.
    orph_inj = 1'b1; tick();
    check("orph_set", {31'd0, ro_arb_orphan_flag}, 32'd1);
    orph_inj = 1'b0; trig_arb_orphan_clear = 1'b1; tick();
    check("orph_clr", {31'd0, ro_arb_orphan_flag}, 32'd0);
    orph_inj = 1'b1; tick();
    check("orph_set_wins", {31'd0, ro_arb_orphan_flag}, 32'd1);
    orph_inj = 1'b0; tick();
    trig_arb_orphan_clear = 1'b0;

    // Reset with tags outstanding: idle next cycle, late results are orphans.
    filt_en = 1'b0; src0_rts = 1'b1; src0_aud = 32'h7777_0000;
    repeat (2) tick();
    rstb = 1'b1; tick();
    rstb = 1'b0; src0_rts = 1'b0;
    #1; chk_idle();
    orph_inj = 1'b1; tick();
    check("post_rst_orphan", {31'd0, ro_arb_orphan_flag}, 32'd1);
    orph_inj = 1'b0; filt_en = 1'b1;

    // Counter wrap on requester 0.
    reset_pulse();
    src0_rts = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      src0_aud = 32'(i);
      tick();
    end
    check("wrap_ffff", {16'd0, ro_src0_count}, 32'h0000_FFFF);
    tick();
    check("wrap_zero", {16'd0, ro_src0_count}, 32'd0);
    src0_rts = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_arbiter.md
FILTER_ARBITER -- requirements
Module: filter_arbiter

Interface
REQ-001 Parameter: TAG_DEPTH, default 4, in-flight sample tag FIFO depth (power of 2, minimum 2).
REQ-002 clk  input  1  master clock; all logic on rising edge.
REQ-003 rstb  input  1  reset, synchronous, active-high.
REQ-004 src0_aud, src1_aud  input  32 each  parallel audio from requester 0 / 1.
REQ-005 src0_rts, src1_rts  input  1 each  requester ready to send.
REQ-006 src0_rtr, src1_rtr  output  1 each  arbiter ready to receive from requester.
REQ-007 flt_aud_in  output  32  sample to the shared filter.
REQ-008 flt_aud_in_rts  output  1 / flt_aud_in_rtr  input  1  filter input handshake.
REQ-009 flt_aud_out  input  32 / flt_aud_out_rts  input  1 / flt_aud_out_rtr  output  1  filter output handshake.
REQ-010 dst0_aud, dst1_aud  output  32 each  filtered audio returned to requester 0 / 1.
REQ-011 dst0_rts, dst1_rts  output  1 each / dst0_rtr, dst1_rtr  input  1 each  return-path handshakes.
REQ-012 rf_arb_en  input  2  per-requester enable; bit k disabled means requester k is never granted.
REQ-013 trig_arb_orphan_clear  input  1  single-cycle pulse clearing ro_arb_orphan_flag.
REQ-014 ro_arb_orphan_flag  output  1  sticky: filter produced a sample with no tag outstanding.
REQ-015 ro_src0_count, ro_src1_count  output  16 each  accepted-sample counters per requester.

Function
REQ-016 Every transfer occurs on a cycle where the sender's rts and receiver's rtr are both high; no other cycle transfers data.
REQ-017 Requester k is eligible when srck_rts=1 and rf_arb_en[k]=1.
REQ-018 Selection is combinational round-robin: one eligible requester wins; both eligible means the requester indicated by priority pointer prio wins.
REQ-019 prio (1 bit) toggles to the loser only on an accepted flt_aud_in transfer; it holds on every other cycle.
REQ-020 flt_aud_in_rts = (any requester eligible) AND (tag FIFO not full); flt_aud_in = winner's srck_aud, else 0.
REQ-021 srck_rtr = (k is winner) AND flt_aud_in_rtr AND (tag FIFO not full); the loser's rtr is 0.
REQ-022 On each accepted input transfer, the winner's index is pushed into the tag FIFO and ro_srck_count increments by 1, wrapping 0xFFFF->0x0000.
REQ-023 Tag FIFO not empty: head tag h routes output; dsth_aud = flt_aud_out, dsth_rts = flt_aud_out_rts, flt_aud_out_rtr = dsth_rtr; the other dst_rts is 0.
REQ-024 On each accepted output transfer, the head tag is popped; the filter therefore returns samples in acceptance order.
REQ-025 Tag FIFO empty: flt_aud_out_rtr = 1 (sample discarded), both dst_rts = 0, and ro_arb_orphan_flag sets if flt_aud_out_rts = 1.
REQ-026 dst0_aud and dst1_aud are 0 whenever the corresponding dst_rts is 0.
REQ-027 Simultaneous push and pop in one cycle is legal at any occupancy except full; when full, push is blocked (REQ-020) even if a pop occurs the same cycle.
REQ-028 Occupancy counter range 0..TAG_DEPTH; read/write pointers wrap modulo TAG_DEPTH.
REQ-029 Clear and set of ro_arb_orphan_flag in the same cycle: set wins.
REQ-030 Changing rf_arb_en mid-stream affects only selection; outstanding tags still drain to their original requester.

Reset
REQ-031 While rstb=1 at a clock edge: tag FIFO empties, pointers and occupancy go to 0, prio=0, both counters go to 0, and ro_arb_orphan_flag goes to 0.
REQ-032 During and after reset with no stimulus: all rts/rtr outputs are 0 except flt_aud_out_rtr=1 (empty FIFO), and all data outputs are 0.
REQ-033 Reset mid-operation discards all outstanding tags; filter outputs arriving afterwards are orphans per REQ-025.

Verification
REQ-034 Both requesters continuously send with rf_arb_en=2'b11 and the filter is always ready -> grants alternate 0,1,0,1 and after 8 transfers both counters read 4.
REQ-035 The filter output stalls (flt_aud_out_rts=0) with TAG_DEPTH=4 -> after 4 accepts, flt_aud_in_rts=0 and both srck_rtr=0; one output pop re-enables accepting on the next cycle.
REQ-036 src0 sends 0x11111111 and src1 sends 0x22222222, then the filter echoes both -> dst0 receives the first sample, dst1 receives the second, and each dst_rts is asserted only for its own sample.
REQ-037 rf_arb_en=2'b01 while both requesters send -> only src0 is served and src1_rtr stays 0; ro_src1_count=0.
REQ-038 flt_aud_out_rts=1 with the FIFO empty, then trig_arb_orphan_clear fires -> the flag reads 1 the cycle after the orphan, reads 0 after the clear, and reads 1 if the clear coincides with a new orphan.
REQ-039 ro_src0_count preset to 0xFFFF by 65535 accepts, then one more accept -> the counter reads 0x0000; rstb pulse mid-stream -> the next cycle matches REQ-032.
